// File: rtl/seg_scan_multiplexer.sv
// seg_scan_multiplexer: multiplexed 7-segment scan driver with blink, dimming, zero suppression and frame snapshots
module seg_scan_multiplexer #(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV_LOG2 = 16,
  parameter int DIM_BITS      = 2,
  parameter int BLINK_FRAMES  = 128
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    En,
  input  logic [4*NUM_DIGITS-1:0] Digits,
  input  logic [NUM_DIGITS-1:0]   DpMask,
  input  logic [NUM_DIGITS-1:0]   BlinkMask,
  input  logic                    LzSuppress,
  input  logic [DIM_BITS-1:0]     Brightness,
  output logic [NUM_DIGITS-1:0]   A,
  output logic [6:0]              C,
  output logic                    Dp,
  output logic                    FrameTick
);
  localparam logic [6:0] SEG_PATTERN_OFF   = 7'h7F;
  localparam logic [6:0] SEG_PATTERN_ZERO  = 7'h40;
  localparam logic [6:0] SEG_PATTERN_ONE   = 7'h79;
  localparam logic [6:0] SEG_PATTERN_TWO   = 7'h24;
  localparam logic [6:0] SEG_PATTERN_THREE = 7'h30;
  localparam logic [6:0] SEG_PATTERN_FOUR  = 7'h19;
  localparam logic [6:0] SEG_PATTERN_FIVE  = 7'h12;
  localparam logic [6:0] SEG_PATTERN_SIX   = 7'h02;
  localparam logic [6:0] SEG_PATTERN_SEVEN = 7'h78;
  localparam logic [6:0] SEG_PATTERN_EIGHT = 7'h00;
  localparam logic [6:0] SEG_PATTERN_NINE  = 7'h10;
  localparam logic [6:0] SEG_PATTERN_H     = 7'h09;
  localparam logic [6:0] SEG_PATTERN_I     = 7'h4F;
  localparam logic [6:0] SEG_PATTERN_G     = 7'h42;
  localparam logic [3:0] LETTER_H = 4'hA;
  localparam logic [3:0] LETTER_I = 4'hB;
  localparam logic [3:0] LETTER_G = 4'hC;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);
  logic [SCAN_DIV_LOG2-1:0] p;
  logic [IW-1:0] idx;
  logic [FW-1:0] fcnt;
  logic phase;
  logic [4*NUM_DIGITS-1:0] s_dig, dig;
  logic [NUM_DIGITS-1:0] s_dm, s_bm, dm, bm, lead;
  logic s_lz, s_ph, lz, ph, fs, acc, blank, lit;
  logic [3:0] code;
  logic [6:0] glyph;
  // the frame-start cycle decodes live inputs; the rest of the frame uses the snapshot
  always_comb begin
    fs = p == '0 && idx == ILAST;
    dig = fs ? Digits : s_dig;
    dm = fs ? DpMask : s_dm;
    bm = fs ? BlinkMask : s_bm;
    lz = fs ? LzSuppress : s_lz;
    ph = fs ? phase : s_ph;
    acc = 1'b1;
    lead = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc = acc && dig[4*k +: 4] == 4'd0;
      lead[k] = acc;
    end
    code = dig[4*idx +: 4];
    blank = !En || (ph && bm[idx]) || (lz && idx != '0 && lead[idx]);
    lit = !blank && p[SCAN_DIV_LOG2-1 -: DIM_BITS] <= Brightness;
    case (code)
      4'd1:     glyph = SEG_PATTERN_ONE;
      4'd2:     glyph = SEG_PATTERN_TWO;
      4'd3:     glyph = SEG_PATTERN_THREE;
      4'd4:     glyph = SEG_PATTERN_FOUR;
      4'd5:     glyph = SEG_PATTERN_FIVE;
      4'd6:     glyph = SEG_PATTERN_SIX;
      4'd7:     glyph = SEG_PATTERN_SEVEN;
      4'd8:     glyph = SEG_PATTERN_EIGHT;
      4'd9:     glyph = SEG_PATTERN_NINE;
      LETTER_H: glyph = SEG_PATTERN_H;
      LETTER_I: glyph = SEG_PATTERN_I;
      LETTER_G: glyph = SEG_PATTERN_G;
      default:  glyph = SEG_PATTERN_ZERO;
    endcase
  end
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      p <= '0;
      idx <= ILAST;
      fcnt <= '0;
      phase <= 1'b0;
      s_dig <= '0;
      s_dm <= '0;
      s_bm <= '0;
      s_lz <= 1'b0;
      s_ph <= 1'b0;
      A <= '1;
      C <= SEG_PATTERN_OFF;
      Dp <= 1'b1;
      FrameTick <= 1'b0;
    end else begin
      p <= p + 1'b1;
      if (p == '1) idx <= idx == '0 ? ILAST : idx - 1'b1;
      if (fs) begin
        s_dig <= Digits;
        s_dm <= DpMask;
        s_bm <= BlinkMask;
        s_lz <= LzSuppress;
        s_ph <= phase;
        fcnt <= fcnt == FLAST ? '0 : fcnt + 1'b1;
        if (fcnt == FLAST) phase <= ~phase;
      end
      A <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      C <= lit ? glyph : SEG_PATTERN_OFF;
      Dp <= lit ? ~dm[idx] : 1'b1;
      FrameTick <= fs;
    end
endmodule

// File: tb/tb_seg_scan_multiplexer.sv
// tb_seg_scan_multiplexer: directed scan, snapshot, suppression, blink, dimming and reset vectors with a scoreboard
module tb_seg_scan_multiplexer;
  localparam logic [6:0] OFF = 7'h7F, ZERO = 7'h40, ONE = 7'h79, TWO = 7'h24, THREE = 7'h30;
  localparam logic [6:0] FOUR = 7'h19, FIVE = 7'h12, SIX = 7'h02, SEVEN = 7'h78, EIGHT = 7'h00;
  localparam logic [6:0] S_H = 7'h09, S_I = 7'h4F, S_G = 7'h42;
  logic Clock = 1'b0, Reset_n = 1'b1, En = 1'b0, LzSuppress = 1'b0;
  logic [15:0] Digits = '0;
  logic [3:0] DpMask = '0, BlinkMask = '0;
  logic [0:0] Brightness = '0;
  logic [3:0] A;
  logic [6:0] C;
  logic Dp, FrameTick;
  typedef struct {int cyc; logic [12:0] v;} exp_t;
  exp_t q[$];
  int cyc = 0, s = 0, errors = 0, checks = 0;
  seg_scan_multiplexer #(.NUM_DIGITS(4), .SCAN_DIV_LOG2(2), .DIM_BITS(1), .BLINK_FRAMES(2)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .En(En), .Digits(Digits), .DpMask(DpMask),
    .BlinkMask(BlinkMask), .LzSuppress(LzSuppress), .Brightness(Brightness),
    .A(A), .C(C), .Dp(Dp), .FrameTick(FrameTick));
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;
  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: {A,C,Dp,FrameTick} got %h expected %h", name, act, exp_v);
    end
  endtask
  always @(negedge Clock) begin
    exp_t e;
    if (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk($sformatf("cycle%0d", e.cyc), {A, C, Dp, FrameTick}, e.v);
    end
  end
  task automatic step(input logic [3:0] a, input logic [6:0] c, input logic dp);
    q.push_back('{cyc + 1, {a, c, dp, s % 16 == 0}});
    @(posedge Clock);
    #1 s++;
  endtask
  task automatic slot(input int j, input logic [6:0] c, input logic dp, input int on);
    for (int k = 0; k < 4; k++) begin
      logic lit;
      lit = c != OFF && k < on;
      step(lit ? ~(4'b1000 >> j) : 4'hF, lit ? c : OFF, lit ? dp : 1'b1);
    end
  endtask
  task automatic frame(input logic [27:0] g, input logic [3:0] dpv, input int on);
    for (int j = 0; j < 4; j++) slot(j, g[27-7*j -: 7], dpv[3-j], on);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    #1 Reset_n = 1'b0;
    repeat (2) @(posedge Clock);
    #1 chk("reset_state", {A, C, Dp, FrameTick}, {4'hF, OFF, 1'b1, 1'b0});
    En = 1'b1; Brightness = 1'b1; Digits = 16'h1234;
    Reset_n = 1'b1; s = 0;
    frame({ONE, TWO, THREE, FOUR}, 4'hF, 4);
    frame({ONE, TWO, THREE, FOUR}, 4'hF, 4);
    slot(0, ONE, 1'b1, 4);
    Digits = 16'h5678;
    slot(1, TWO, 1'b1, 4);
    slot(2, THREE, 1'b1, 4);
    slot(3, FOUR, 1'b1, 4);
    frame({FIVE, SIX, SEVEN, EIGHT}, 4'hF, 4);
    LzSuppress = 1'b1; Digits = 16'h0050;
    frame({OFF, OFF, FIVE, ZERO}, 4'hF, 4);
    Digits = 16'h0000;
    frame({OFF, OFF, OFF, ZERO}, 4'hF, 4);
    Digits = 16'h0102;
    frame({OFF, ONE, ZERO, TWO}, 4'hF, 4);
    LzSuppress = 1'b0; Digits = 16'hABCF; DpMask = 4'b0101;
    frame({S_H, S_I, S_G, ZERO}, 4'b1010, 4);
    @(negedge Clock);
    #1 Reset_n = 1'b0;
    Digits = 16'h1234; DpMask = 4'b0000; BlinkMask = 4'b0001;
    @(posedge Clock);
    #1 Reset_n = 1'b1; s = 0;
    for (int f = 0; f < 6; f++) frame({ONE, TWO, THREE, (f == 2 || f == 3) ? OFF : FOUR}, 4'hF, 4);
    BlinkMask = 4'b0000; Brightness = 1'b0;
    frame({ONE, TWO, THREE, FOUR}, 4'hF, 2);
    En = 1'b0; DpMask = 4'b1111;
    frame({OFF, OFF, OFF, OFF}, 4'hF, 4);
    En = 1'b1; Brightness = 1'b1;
    frame({ONE, TWO, THREE, FOUR}, 4'h0, 4);
    slot(0, ONE, 1'b0, 4);
    step(4'b1011, TWO, 1'b0);
    step(4'b1011, TWO, 1'b0);
    @(negedge Clock);
    #1 Reset_n = 1'b0;
    #1 chk("async_reset", {A, C, Dp, FrameTick}, {4'hF, OFF, 1'b1, 1'b0});
    repeat (2) @(posedge Clock);
    #1 chk("reset_hold", {A, C, Dp, FrameTick}, {4'hF, OFF, 1'b1, 1'b0});
    Reset_n = 1'b1; s = 0;
    frame({ONE, TWO, THREE, FOUR}, 4'h0, 4);
    @(negedge Clock);
    #1 checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
